// File: rtl/ps2_keycode_rx_if.sv
// PS/2 keyboard pins plus decoded keycode/strobe outputs.
// The receiver uses the slave modport; the keyboard-side driver uses master.
interface ps2_keycode_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       extended;
    logic       make_pulse;
    logic       break_pulse;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  keycode, extended, make_pulse, break_pulse,
        input  byte_valid, byte_data, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output keycode, extended, make_pulse, break_pulse,
        output byte_valid, byte_data, frame_err
    );
endinterface

// File: rtl/ps2_keycode_rx.sv
// PS/2 Set-2 receiver: frames 11-bit words off the keyboard pins and tracks
// the currently held key (make/break/E0 decoding) with registered strobes.
module ps2_keycode_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic            clk,
    input  logic            rst,
    ps2_keycode_rx_if.slave bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t        state_q;
    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          dat_meta_q, dat_sync_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          ext_pend_q, brk_pend_q;
    logic [7:0]    keycode_q;
    logic          extended_q;
    logic          make_pulse_q, break_pulse_q;
    logic          byte_valid_q;
    logic [7:0]    byte_data_q;
    logic          frame_err_q;

    logic fall, timeout, frame_ok, good_byte, bad_frame;

    always_comb begin
        fall      = clk_prev_q & ~clk_sync_q;
        timer_d   = timer_q + TW'(1);
        timeout   = (state_q != S_IDLE) && !fall && (timer_d == TMAX);
        frame_ok  = ((^shift_q) ^ parity_q) && dat_sync_q;
        good_byte = (state_q == S_STOP) && fall && frame_ok;
        bad_frame = ((state_q == S_STOP) && fall && !frame_ok) || timeout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            clk_meta_q    <= 1'b0;
            clk_sync_q    <= 1'b0;
            clk_prev_q    <= 1'b0;
            dat_meta_q    <= 1'b0;
            dat_sync_q    <= 1'b0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            timer_q       <= '0;
            ext_pend_q    <= 1'b0;
            brk_pend_q    <= 1'b0;
            keycode_q     <= '0;
            extended_q    <= 1'b0;
            make_pulse_q  <= 1'b0;
            break_pulse_q <= 1'b0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            clk_meta_q    <= bus.ps2_clk;
            clk_sync_q    <= clk_meta_q;
            clk_prev_q    <= clk_sync_q;
            dat_meta_q    <= bus.ps2_data;
            dat_sync_q    <= dat_meta_q;
            make_pulse_q  <= 1'b0;
            break_pulse_q <= 1'b0;
            byte_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;

            if (state_q == S_IDLE || fall || timeout) timer_q <= '0;
            else                                      timer_q <= timer_d;

            if (timeout) begin
                state_q <= S_IDLE;
            end else if (fall) begin
                case (state_q)
                    S_IDLE: begin
                        if (!dat_sync_q) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        shift_q   <= {dat_sync_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
                    end
                    S_PARITY: begin
                        parity_q <= dat_sync_q;
                        state_q  <= S_STOP;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end

            if (bad_frame) begin
                frame_err_q <= 1'b1;
                ext_pend_q  <= 1'b0;
                brk_pend_q  <= 1'b0;
            end

            // Decode straight from the shift register so key outputs land with byte_valid.
            if (good_byte) begin
                byte_valid_q <= 1'b1;
                byte_data_q  <= shift_q;
                if (shift_q == 8'hE0) begin
                    ext_pend_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_pend_q <= 1'b1;
                end else begin
                    ext_pend_q <= 1'b0;
                    brk_pend_q <= 1'b0;
                    if (shift_q != 8'h00 && shift_q != 8'hFF) begin
                        if (brk_pend_q) begin
                            if (shift_q == keycode_q && ext_pend_q == extended_q) begin
                                keycode_q     <= '0;
                                extended_q    <= 1'b0;
                                break_pulse_q <= 1'b1;
                            end
                        end else begin
                            keycode_q    <= shift_q;
                            extended_q   <= ext_pend_q;
                            make_pulse_q <= ({ext_pend_q, shift_q} != {extended_q, keycode_q});
                        end
                    end
                end
            end
        end
    end

    assign bus.keycode     = keycode_q;
    assign bus.extended    = extended_q;
    assign bus.make_pulse  = make_pulse_q;
    assign bus.break_pulse = break_pulse_q;
    assign bus.byte_valid  = byte_valid_q;
    assign bus.byte_data   = byte_data_q;
    assign bus.frame_err   = frame_err_q;
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: table of directed frames, timeout and reset
// sequences, then random frames checked against a key-tracking model.
module tb_ps2_keycode_rx;
    localparam int unsigned TO = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_keycode_rx_if bus ();
    ps2_keycode_rx #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int make_n = 0, brk_n = 0, bv_n = 0, err_n = 0;
    logic [7:0] last_good = 8'h00;

    // Model of the held key, derived from the make/break/E0 rules.
    logic [7:0] m_key = 8'h00;
    bit m_ext = 0, m_ep = 0, m_bp = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.make_pulse)  make_n++;
            if (bus.break_pulse) brk_n++;
            if (bus.byte_valid)  bv_n++;
            if (bus.frame_err)   err_n++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic v);
        @(negedge clk) bus.ps2_data = v;
        repeat (4) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bp);
        ps2_bit(~bs);
        bus.ps2_data = 1'b1;
    endtask

    task automatic frame_check(input string tag, input logic [7:0] b, input bit bp, input bit bs,
                               input logic [7:0] ek, input bit ee, input int em, input int eb);
        int m0, b0, v0, e0;
        bit good;
        m0 = make_n; b0 = brk_n; v0 = bv_n; e0 = err_n;
        good = !(bp || bs);
        send_frame(b, bp, bs);
        if (good) last_good = b;
        chk({tag, "_keycode"}, int'(bus.keycode), int'(ek));
        chk({tag, "_extended"}, int'(bus.extended), int'(ee));
        chk({tag, "_make"}, make_n - m0, em);
        chk({tag, "_break"}, brk_n - b0, eb);
        chk({tag, "_valid"}, bv_n - v0, good ? 1 : 0);
        chk({tag, "_err"}, err_n - e0, good ? 0 : 1);
        chk({tag, "_byte_data"}, int'(bus.byte_data), int'(last_good));
    endtask

    task automatic model_step(input logic [7:0] b, input bit ok, output int mk, output int bk);
        mk = 0; bk = 0;
        if (!ok) begin
            m_ep = 0; m_bp = 0;
            return;
        end
        if (b == 8'hE0) m_ep = 1;
        else if (b == 8'hF0) m_bp = 1;
        else begin
            if (b != 8'h00 && b != 8'hFF) begin
                if (m_bp) begin
                    if (b == m_key && m_ep == m_ext) begin
                        m_key = 8'h00; m_ext = 0; bk = 1;
                    end
                end else begin
                    if ({m_ep, b} != {m_ext, m_key}) mk = 1;
                    m_key = b; m_ext = m_ep;
                end
            end
            m_ep = 0; m_bp = 0;
        end
    endtask

    task automatic model_frame(input string tag, input logic [7:0] b, input bit bp);
        int mk, bk;
        model_step(b, !bp, mk, bk);
        frame_check(tag, b, bp, 1'b0, m_key, m_ext, mk, bk);
    endtask

    typedef struct {
        logic [7:0] b;
        bit         bp;
        bit         bs;
        logic [7:0] key;
        bit         ext;
        int         mk;
        int         bk;
    } vec_t;
    vec_t tbl[22];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int first_k, e0, v0, sel;
        logic [7:0] b;
        bit bp;

        tbl[0]  = '{8'hE0, 0, 0, 8'h00, 0, 0, 0};
        tbl[1]  = '{8'h75, 0, 0, 8'h75, 1, 1, 0};
        tbl[2]  = '{8'hE0, 0, 0, 8'h75, 1, 0, 0};
        tbl[3]  = '{8'hF0, 0, 0, 8'h75, 1, 0, 0};
        tbl[4]  = '{8'h75, 0, 0, 8'h00, 0, 0, 1};
        tbl[5]  = '{8'h1C, 0, 0, 8'h1C, 0, 1, 0};
        tbl[6]  = '{8'h6B, 1, 0, 8'h1C, 0, 0, 0};
        tbl[7]  = '{8'h6B, 0, 1, 8'h1C, 0, 0, 0};
        tbl[8]  = '{8'hE0, 0, 0, 8'h1C, 0, 0, 0};
        tbl[9]  = '{8'h11, 1, 0, 8'h1C, 0, 0, 0};
        tbl[10] = '{8'h75, 0, 0, 8'h75, 0, 1, 0};
        tbl[11] = '{8'hE0, 0, 0, 8'h75, 0, 0, 0};
        tbl[12] = '{8'h74, 0, 0, 8'h74, 1, 1, 0};
        tbl[13] = '{8'hE0, 0, 0, 8'h74, 1, 0, 0};
        tbl[14] = '{8'h74, 0, 0, 8'h74, 1, 0, 0};
        tbl[15] = '{8'hE0, 0, 0, 8'h74, 1, 0, 0};
        tbl[16] = '{8'h74, 0, 0, 8'h74, 1, 0, 0};
        tbl[17] = '{8'hE0, 0, 0, 8'h74, 1, 0, 0};
        tbl[18] = '{8'h6B, 0, 0, 8'h6B, 1, 1, 0};
        tbl[19] = '{8'hE0, 0, 0, 8'h6B, 1, 0, 0};
        tbl[20] = '{8'hF0, 0, 0, 8'h6B, 1, 0, 0};
        tbl[21] = '{8'h74, 0, 0, 8'h6B, 1, 0, 0};

        rst = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_keycode", int'(bus.keycode), 0);
        chk("reset_byte_data", int'(bus.byte_data), 0);
        chk("reset_strobes", int'({bus.extended, bus.make_pulse, bus.break_pulse,
                                   bus.byte_valid, bus.frame_err}), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 22; i++)
            frame_check($sformatf("vec%0d", i), tbl[i].b, tbl[i].bp, tbl[i].bs,
                        tbl[i].key, tbl[i].ext, tbl[i].mk, tbl[i].bk);

        // Timeout: start bit plus 4 data bits, then the clock stays high.
        e0 = err_n; v0 = bv_n;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        @(negedge clk) bus.ps2_data = 1'b0;
        repeat (4) @(negedge clk);
        bus.ps2_clk = 1'b0;
        first_k = -1;
        for (int k = 1; k <= int'(TO) + 10; k++) begin
            @(negedge clk);
            if (k == 8) bus.ps2_clk = 1'b1;
            if (bus.frame_err && first_k < 0) first_k = k;
        end
        bus.ps2_data = 1'b1;
        chk("timeout_latency", first_k, int'(TO) + 2);
        chk("timeout_err_count", err_n - e0, 1);
        chk("timeout_no_valid", bv_n - v0, 0);
        chk("timeout_keycode", int'(bus.keycode), 8'h6B);
        frame_check("after_timeout", 8'h74, 0, 0, 8'h74, 0, 1, 0);

        // Reset in the middle of a frame.
        for (int i = 0; i < 5; i++) ps2_bit(i[0]);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("midrst_keycode", int'(bus.keycode), 0);
        chk("midrst_byte_data", int'(bus.byte_data), 0);
        chk("midrst_strobes", int'({bus.extended, bus.make_pulse, bus.break_pulse,
                                    bus.byte_valid, bus.frame_err}), 0);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        m_key = 8'h00; m_ext = 0; m_ep = 0; m_bp = 0;
        repeat (5) @(negedge clk);
        model_frame("post_rst_e0", 8'hE0, 0);
        model_frame("post_rst_72", 8'h72, 0);
        chk("post_rst_key72", int'(bus.keycode), 8'h72);
        chk("post_rst_ext", int'(bus.extended), 1);

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1: b = 8'hE0;
                2:    b = 8'hF0;
                3:    b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                4, 5, 6, 7: begin
                    case ($urandom_range(0, 3))
                        0:       b = 8'h75;
                        1:       b = 8'h72;
                        2:       b = 8'h6B;
                        default: b = 8'h74;
                    endcase
                end
                default: b = 8'($urandom);
            endcase
            bp = ($urandom_range(0, 9) == 0);
            model_frame($sformatf("rnd%0d", n), b, bp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_keycode_rx.md
Name: ps2_keycode_rx

Overview:
- Receives scan codes from a PS/2 keyboard on the ps2_clk and ps2_data pins.
- Decodes Set-2 make, break (0xF0) and extended (0xE0) sequences.
- Presents the currently held key as an 8-bit keycode. 0x00 means no key is held.
- Supplies the keycode input of the character-movement controller. That controller compares against the bare arrow codes 0x75, 0x72, 0x6B and 0x74, so the E0 prefix is reported separately on the extended port.

Parameters:
- TIMEOUT_CYCLES, 100000: clk cycles with no ps2_clk falling edge before a partial frame is abandoned (2 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk
- ps2_data  in  1  raw PS/2 data pin, asynchronous to clk
- keycode  out  8  make code of the currently held key; 0x00 when none
- extended  out  1  1 when the held key was prefixed by 0xE0
- make_pulse  out  1  one-cycle strobe when {extended,keycode} changes to a new key
- break_pulse  out  1  one-cycle strobe when the held key is released
- byte_valid  out  1  one-cycle strobe for each correctly framed byte
- byte_data  out  8  last correctly framed byte; held until the next one
- frame_err  out  1  one-cycle strobe on a parity, stop-bit or timeout error

Behaviour:
- Clock and reset: single clk domain. While rst=1, every register and output is 0: keycode=0x00, extended=0, all strobes=0, byte_data=0x00, FSM=IDLE, pending flags=0.
- Synchronisers: ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- Edge detect: a falling edge is synchronised clk previously 1 and now 0. The data bit is sampled in that same cycle. Latency from pin edge to sample is 3 clk cycles.
- Frame format: 11 bits.
  - Start bit = 0.
  - 8 data bits, LSB first, shifted into bit 7 and moving right.
  - Odd parity bit.
  - Stop bit = 1.
- Frame FSM states and transitions:
  - IDLE: on a falling edge with data=0, go to DATA with bit_cnt=0. A falling edge with data=1 is ignored and raises no error.
  - DATA: shift one bit per falling edge. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: on the falling edge, check two conditions: (XOR of the 8 data bits XOR parity bit) == 1, and stop bit == 1.
    - Both pass: byte_data is updated and byte_valid=1 in the cycle after the stop sample.
    - Either fails: frame_err=1 in that cycle and the byte is discarded.
    - In both cases go to IDLE.
- Timeout:
  - The counter clears on every falling edge and is held at 0 in IDLE.
  - In any non-IDLE state, reaching TIMEOUT_CYCLES-1 without an edge forces IDLE and pulses frame_err.
  - Timeout and byte_valid are mutually exclusive by construction.
- Decoder (acts only on byte_valid):
  - 0xE0: set ext_pend=1.
  - 0xF0: set brk_pend=1.
  - 0x00 or 0xFF (keyboard error/overrun): ignored; clear both pending flags.
  - Other byte b with brk_pend=1: if b==keycode and ext_pend==extended, set keycode=0x00, extended=0 and pulse break_pulse. Otherwise no output change (break of a non-held key).
  - Other byte b with brk_pend=0: set keycode=b and extended=ext_pend. Pulse make_pulse only if {ext_pend,b} differs from the current {extended,keycode}, so typematic repeats give no strobe.
  - Both pending flags clear after any non-prefix byte and on frame_err.
- Output timing: keycode, extended and the strobes update in the same cycle as the byte_valid that caused them. All outputs are registered.
- Reset mid-frame: asynchronously aborts the frame and clears decoder state. The next complete frame after release decodes normally.

Test Plan:
1. Frames E0 (parity 0), then 75 (parity 0) -> two byte_valid strobes; keycode=0x75, extended=1; exactly one make_pulse.
2. From state 1, send E0, F0 (parity 1), 75 -> keycode=0x00, extended=0; one break_pulse; no make_pulse.
3. Frame 6B sent with parity bit 1 (wrong) -> frame_err=1 for one cycle; no byte_valid; keycode unchanged. Then stop bit 0 on a valid-parity frame -> frame_err.
4. Start bit plus 4 data bits, then ps2_clk held high -> frame_err exactly TIMEOUT_CYCLES-1 cycles after the last edge; FSM in IDLE. A following clean 74 frame (parity 1) -> byte_data=0x74, byte_valid.
5. E0 74 three times -> keycode=0x74, one make_pulse. Then E0 6B -> keycode=0x6B, one make_pulse. Then E0 F0 74 -> no change, no break_pulse.
6. rst pulsed after 5 bits of a frame -> all outputs 0 immediately. Then a full E0 72 sequence -> keycode=0x72, extended=1.
